// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of one shared 32-bit ALU

// Combinational ALU with {Overflow, CarryOut, Zero} flags; CarryOut means borrow on SUB.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             carry_out,
    output logic             zero
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    // Operation decode; flags other than Zero are only meaningful for ADD/SUB.
    always_comb begin
        result    = '0;
        overflow  = 1'b0;
        carry_out = 1'b0;
        case (op)
            3'b000: result = a & b;
            3'b001: result = a | b;
            3'b010: begin
                result    = sum[WIDTH-1:0];
                carry_out = sum[WIDTH];
                overflow  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            3'b011: result = {{(WIDTH-1){1'b0}}, diff[WIDTH]};
            3'b100: result = a ^ b;
            3'b101: result = ~(a | b);
            3'b110: begin
                result    = diff[WIDTH-1:0];
                carry_out = diff[WIDTH];
                overflow  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            default: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
        endcase
    end

    assign zero = (result == '0);
endmodule

// Arbitrates two requesters onto the shared ALU: IDLE -> EXEC -> RESP.
module alu_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_A,
    input  logic [DATA_WIDTH-1:0] req0_B,
    input  logic [2:0]            req0_op,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_A,
    input  logic [DATA_WIDTH-1:0] req1_B,
    input  logic [2:0]            req1_op,
    output logic                  resp0_valid,
    input  logic                  resp0_ready,
    output logic                  resp1_valid,
    input  logic                  resp1_ready,
    output logic [DATA_WIDTH-1:0] resp_result,
    output logic [2:0]            resp_flags,
    output logic                  busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state;
    logic                  last_grant;
    logic                  grant_id;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [2:0]            op_code;

    logic                  gnt_sel;
    logic                  resp_hs;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_ovf;
    logic                  alu_cout;
    logic                  alu_zero;

    // On a tie the requester that did not win last time gets the slot.
    assign gnt_sel    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign req0_ready = resetn && (state == S_IDLE) && req0_valid && !gnt_sel;
    assign req1_ready = resetn && (state == S_IDLE) && req1_valid &&  gnt_sel;
    assign resp_hs    = grant_id ? resp1_ready : resp0_ready;

    alu #(.WIDTH(DATA_WIDTH)) u_alu (
        .a         (op_a),
        .b         (op_b),
        .op        (op_code),
        .result    (alu_result),
        .overflow  (alu_ovf),
        .carry_out (alu_cout),
        .zero      (alu_zero)
    );

    // Control FSM with registered response/busy outputs; reset drops any in-flight op.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            last_grant  <= 1'b1;
            grant_id    <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            op_code     <= '0;
            resp_result <= '0;
            resp_flags  <= '0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req0_valid || req1_valid) begin
                        grant_id <= gnt_sel;
                        op_a     <= gnt_sel ? req1_A  : req0_A;
                        op_b     <= gnt_sel ? req1_B  : req0_B;
                        op_code  <= gnt_sel ? req1_op : req0_op;
                        state    <= S_EXEC;
                        busy     <= 1'b1;
                    end
                end
                S_EXEC: begin
                    resp_result <= alu_result;
                    resp_flags  <= {alu_ovf, alu_cout, alu_zero};
                    resp0_valid <= !grant_id;
                    resp1_valid <= grant_id;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (resp_hs) begin
                        last_grant  <= grant_id;
                        resp0_valid <= 1'b0;
                        resp1_valid <= 1'b0;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
